// File: rtl/boid_frame_plotter.sv
// Per-frame boid plotter: flips buffers, starts the clear sweep, then draws one pixel per boid.
// Optional build macro BOID_PLOT_2X2_EN draws each boid as a clipped 2x2 block.
module boid_frame_plotter #(
    parameter int NUM_BOIDS  = 16,
    parameter int IDX_W      = 4,
    parameter int COORD_W    = 5,
    parameter int GRID_W     = 32,
    parameter int GRID_H     = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    output logic [IDX_W-1:0]      pos_addr,
    input  logic [COORD_W-1:0]    pos_x,
    input  logic [COORD_W-1:0]    pos_y,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic                  write_data,
    output logic                  swap,
    output logic                  clear_en,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SWAP  = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam int CNT_W = ADDR_WIDTH + 1;

    logic [2:0]            state;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      pos_addr_q;
    logic [COORD_W-1:0]    px;
    logic [COORD_W-1:0]    py;
    logic [CNT_W-1:0]      clear_cnt;
    logic                  overrun_q;
    logic [COORD_W:0]      xx;
    logic [COORD_W:0]      yy;
    logic                  in_grid;
    logic [ADDR_WIDTH-1:0] addr_calc;
    logic                  last_boid;
    logic                  boid_finished;
`ifdef BOID_PLOT_2X2_EN
    logic [1:0]            sub;
`endif

    assign last_boid = (idx == IDX_W'(NUM_BOIDS - 1));
`ifdef BOID_PLOT_2X2_EN
    assign boid_finished = (sub == 2'd3);
`else
    assign boid_finished = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            idx        <= '0;
            pos_addr_q <= '0;
            px         <= '0;
            py         <= '0;
            clear_cnt  <= '0;
            overrun_q  <= 1'b0;
`ifdef BOID_PLOT_2X2_EN
            sub        <= '0;
`endif
        end else begin
            if (frame_start && state != S_IDLE)
                overrun_q <= 1'b1;
            if (clear_cnt != '0)
                clear_cnt <= clear_cnt - 1'b1;
            case (state)
                S_IDLE: begin
                    if (frame_start)
                        state <= S_SWAP;
                end
                S_SWAP: begin
                    idx        <= '0;
                    pos_addr_q <= '0;
                    clear_cnt  <= CNT_W'(DEPTH);
                    state      <= S_FETCH;
                end
                S_FETCH: state <= S_WAIT;
                S_WAIT: begin
                    px    <= pos_x;
                    py    <= pos_y;
`ifdef BOID_PLOT_2X2_EN
                    sub   <= '0;
`endif
                    state <= S_WRITE;
                end
                S_WRITE: begin
`ifdef BOID_PLOT_2X2_EN
                    sub <= sub + 1'b1;
`endif
                    if (boid_finished) begin
                        idx <= idx + 1'b1;
                        // pos_addr keeps the final index once the table walk ends
                        if (last_boid) begin
                            state <= S_DONE;
                        end else begin
                            pos_addr_q <= idx + 1'b1;
                            state      <= S_FETCH;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
`ifdef BOID_PLOT_2X2_EN
        xx = {1'b0, px} + {{COORD_W{1'b0}}, sub[0]};
        yy = {1'b0, py} + {{COORD_W{1'b0}}, sub[1]};
`else
        xx = {1'b0, px};
        yy = {1'b0, py};
`endif
        in_grid   = (32'(xx) < 32'(GRID_W)) && (32'(yy) < 32'(GRID_H));
        addr_calc = ADDR_WIDTH'(yy) * ADDR_WIDTH'(GRID_W) + ADDR_WIDTH'(xx);
        we         = (state == S_WRITE) && in_grid;
        write_data = we;
        write_addr = we ? addr_calc : '0;
        swap       = (state == S_SWAP);
        clear_en   = (clear_cnt != '0);
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
    end

    assign pos_addr = pos_addr_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_boid_frame_plotter.sv
// Scoreboard bench for boid_frame_plotter: expected swap/write/done events are queued per frame,
// a negedge monitor pops and compares them; direct checks cover reset, clear sweep, overrun, busy.
module tb_boid_frame_plotter;

    localparam int NB    = 16;
    localparam int CW    = 6;
    localparam int GW    = 32;
    localparam int GH    = 32;
    localparam int DEP   = 1024;
    localparam int AW    = 10;
`ifdef BOID_PLOT_2X2_EN
    localparam int PER   = 6;
    localparam int SUBS  = 4;
`else
    localparam int PER   = 3;
    localparam int SUBS  = 1;
`endif
    localparam int K_SWAP = 1;
    localparam int K_WE   = 2;
    localparam int K_DONE = 3;

    typedef struct {
        int cyc;
        int kind;
        int addr;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          frame_start = 1'b0;
    logic [3:0]    pos_addr;
    logic [CW-1:0] pos_x = '0;
    logic [CW-1:0] pos_y = '0;
    logic          we;
    logic [AW-1:0] write_addr;
    logic          write_data;
    logic          swap;
    logic          clear_en;
    logic          busy;
    logic          done;
    logic          overrun;

    boid_frame_plotter #(
        .NUM_BOIDS (NB),
        .IDX_W     (4),
        .COORD_W   (CW),
        .GRID_W    (GW),
        .GRID_H    (GH),
        .DEPTH     (DEP),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_start(frame_start),
        .pos_addr   (pos_addr),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .we         (we),
        .write_addr (write_addr),
        .write_data (write_data),
        .swap       (swap),
        .clear_en   (clear_en),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // position table with one-cycle read latency
    int tab_x [NB] = '{3, 31, 0, 10, 17, 32, 5, 0, 63, 30, 12, 1, 31, 8, 25, 16};
    int tab_y [NB] = '{2, 31, 0, 5, 29, 0, 31, 40, 63, 1, 12, 30, 0, 20, 3, 16};
    always @(posedge clk) begin
        pos_x <= CW'(tab_x[pos_addr]);
        pos_y <= CW'(tab_y[pos_addr]);
    end

    ev_t exp_q[$];
    int  n_cmp  = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b0;
    int  clr_first = 0;
    int  clr_last  = 0;
    int  clr_cnt   = 0;

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s @%0d: got %0d, want %0d", name, cyc + 1, got, want);
        end
    endtask

    task automatic handle(input int s, input int kind, input int addr);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event @%0d: got kind %0d addr %0d, want nothing", s, kind, addr);
        end else begin
            e = exp_q.pop_front();
            if (e.cyc != s || e.kind != kind || e.addr != addr) begin
                n_fail++;
                $display("FAIL event @%0d: got kind %0d addr %0d, want kind %0d addr %0d @%0d",
                         s, kind, addr, e.kind, e.addr, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (swap) handle(cyc + 1, K_SWAP, 0);
            if (we) begin
                handle(cyc + 1, K_WE, int'(write_addr));
                chk("write_data", int'(write_data), 1);
            end else if (busy) begin
                chk("idle_addr", int'(write_addr), 0);
                chk("idle_data", int'(write_data), 0);
            end
            if (done) handle(cyc + 1, K_DONE, 0);
            if (clear_en) begin
                if (clr_cnt == 0) clr_first = cyc + 1;
                clr_last = cyc + 1;
                clr_cnt++;
            end
        end
    end

    task automatic push(input int c, input int k, input int a);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.addr = a;
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input int t, input int limit);
        int x, y;
        if (t + 1 <= limit) push(t + 1, K_SWAP, 0);
        for (int k = 0; k < NB; k++) begin
            for (int s = 0; s < SUBS; s++) begin
                x = tab_x[k] + (s % 2);
                y = tab_y[k] + (s / 2);
                if (x < GW && y < GH && t + 4 + PER * k + s <= limit)
                    push(t + 4 + PER * k + s, K_WE, y * GW + x);
            end
        end
        if (t + 2 + PER * NB <= limit) push(t + 2 + PER * NB, K_DONE, 0);
    endtask

    task automatic goto(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int t1, t2, t3, dn;
        t1 = 20;
        t2 = 1100;
        t3 = 1200;

        goto(5);
        reset = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_we", int'(we), 0);
        chk("rst_swap", int'(swap), 0);
        chk("rst_clear_en", int'(clear_en), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_write_addr", int'(write_addr), 0);
        chk("rst_write_data", int'(write_data), 0);
        chk("rst_pos_addr", int'(pos_addr), 0);
        mon_en = 1'b1;

        // frame 1 with a stray frame_start mid-frame
        dn = t1 + 2 + PER * NB;
        push_frame(t1, 1 << 30);
        goto(t1 - 1);
        chk("busy_before", int'(busy), 0);
        frame_start = 1'b1;
        goto(t1);
        frame_start = 1'b0;
        chk("busy_first", int'(busy), 1);
        goto(t1 + 9);
        frame_start = 1'b1;
        goto(t1 + 10);
        frame_start = 1'b0;
        chk("overrun_set", int'(overrun), 1);
        goto(dn - 1);
        chk("busy_last", int'(busy), 1);
        goto(dn);
        chk("busy_after", int'(busy), 0);
        chk("pos_addr_hold", int'(pos_addr), NB - 1);
        goto(t1 + 1030);
        chk("clear_first", clr_first, t1 + 2);
        chk("clear_last", clr_last, t1 + 1 + DEP);
        chk("clear_count", clr_cnt, DEP);
        chk("overrun_sticky", int'(overrun), 1);
        chk("f1_events_left", exp_q.size(), 0);

        // frame 2 aborted by reset at t2+20
        push_frame(t2, t2 + 20);
        goto(t2 - 1);
        frame_start = 1'b1;
        goto(t2);
        frame_start = 1'b0;
        goto(t2 + 4);
        chk("overrun_held", int'(overrun), 1);
        goto(t2 + 19);
        chk("clear_before_rst", int'(clear_en), 1);
        reset = 1'b1;
        goto(t2 + 20);
        reset = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_we", int'(we), 0);
        chk("abort_clear_en", int'(clear_en), 0);
        chk("abort_overrun", int'(overrun), 0);
        chk("abort_swap", int'(swap), 0);
        chk("f2_events_left", exp_q.size(), 0);

        // frame 3: clean restart
        dn = t3 + 2 + PER * NB;
        push_frame(t3, 1 << 30);
        goto(t3 - 1);
        frame_start = 1'b1;
        goto(t3);
        frame_start = 1'b0;
        goto(dn + 5);
        chk("f3_busy", int'(busy), 0);
        chk("f3_overrun", int'(overrun), 0);
        chk("f3_clear_en", int'(clear_en), 1);
        chk("f3_events_left", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
